// File: rtl/frame_stack.sv
// ---------------------------------------------------------------------------
// frame_stack
//
// Operand stack with hardware call-frame tracking for the WebAssembly core.
// Operand and local entries share one memory; a separate frame-base stack
// lets CALL and RETURN move the underflow boundary (base) without help from
// the control unit. RETURN with results that must move down runs as a
// multi-cycle copy, one entry per cycle, with o_req_ready held low.
//
// Optional build macro:
//   FRAME_STACK_HIGH_WATER_EN  - track the maximum index reached since reset
//                                on o_high_water (tied to 0 otherwise).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_req_valid       request present
//   o_req_ready       block can accept a request (low during a RETURN copy)
//   i_op              0 NOP,1 PUSH,2 POP,3 REPLACE,4 CALL,5 RETURN,
//                     6 LOCAL_GET,7 LOCAL_SET
//   i_arg             count/offset operand
//   i_data            write data
//   i_drop            LOCAL_SET also pops the top of stack
//   o_resp_valid      one-cycle pulse when a request completes
//   o_status          0 NONE,1 EMPTY,2 FULL,3 UNDERFLOW,4 OVERFLOW,
//                     5 BAD_OFFSET,6 FRAME_OVERFLOW,7 FRAME_UNDERFLOW
//   o_index           entry count
//   o_base            current frame base
//   o_frame_depth     number of active frames
//   o_top0/1/2        stack[index-1], stack[index-2], stack[index-3] (0 below 0)
//   o_high_water      maximum index since reset (optional)
// ---------------------------------------------------------------------------
module frame_stack #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 7,
    parameter int FRAMES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_op,
    input  logic [DEPTH:0]    i_arg,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_drop,
    output logic              o_resp_valid,
    output logic [2:0]        o_status,
    output logic [DEPTH:0]    o_index,
    output logic [DEPTH:0]    o_base,
    output logic [FRAMES:0]   o_frame_depth,
    output logic [WIDTH-1:0]  o_top0,
    output logic [WIDTH-1:0]  o_top1,
    output logic [WIDTH-1:0]  o_top2,
    output logic [DEPTH:0]    o_high_water
);

    localparam logic [DEPTH:0]  CAP  = {1'b1, {DEPTH{1'b0}}};
    localparam logic [FRAMES:0] FCAP = {1'b1, {FRAMES{1'b0}}};
    localparam logic [DEPTH:0]  ONE  = (DEPTH+1)'(1);

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_PUSH      = 3'd1,
        OP_POP       = 3'd2,
        OP_REPLACE   = 3'd3,
        OP_CALL      = 3'd4,
        OP_RETURN    = 3'd5,
        OP_LOCAL_GET = 3'd6,
        OP_LOCAL_SET = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_NONE            = 3'd0,
        ST_EMPTY           = 3'd1,
        ST_FULL            = 3'd2,
        ST_UNDERFLOW       = 3'd3,
        ST_OVERFLOW        = 3'd4,
        ST_BAD_OFFSET      = 3'd5,
        ST_FRAME_OVERFLOW  = 3'd6,
        ST_FRAME_UNDERFLOW = 3'd7
    } status_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_COPY = 1'b1
    } state_e;

    // Storage
    logic [WIDTH-1:0] r_mem    [2**DEPTH];
    logic [DEPTH:0]   r_fstack [2**FRAMES];

    // Control / architectural state
    state_e           r_state;
    logic             r_req_ready;
    logic             r_resp_valid;
    status_e          r_status;
    logic [DEPTH:0]   r_index;
    logic [DEPTH:0]   r_base;
    logic [FRAMES:0]  r_fdepth;
    logic [WIDTH-1:0] r_top0, r_top1, r_top2;

    // Copy engine: source/destination pointers and entries left to move
    logic [DEPTH-1:0] r_src;
    logic [DEPTH:0]   r_dst;
    logic [DEPTH:0]   r_cnt;

    op_e              w_op;
    logic [DEPTH:0]   w_avail;
    logic [DEPTH-1:0] w_local_addr;
    logic [FRAMES-1:0] w_fd_top;
    logic [DEPTH:0]   w_popped;

    logic [DEPTH:0]   w_nxt_index;
    logic [DEPTH:0]   w_nxt_base;
    logic [FRAMES:0]  w_nxt_fdepth;
    logic             w_we;
    logic [DEPTH-1:0] w_wa;
    logic [WIDTH-1:0] w_wd;
    logic             w_fpush;
    logic             w_complete;
    logic             w_start_copy;
    status_e          w_err;
    status_e          w_status;
    logic [WIDTH-1:0] w_tap [3];

    assign w_op         = op_e'(i_op);
    // index >= base always holds, so this difference never wraps.
    assign w_avail      = r_index - r_base;
    // Only used once i_arg < w_avail has been checked, so it stays in range.
    assign w_local_addr = r_base[DEPTH-1:0] + i_arg[DEPTH-1:0];
    assign w_fd_top     = r_fdepth[FRAMES-1:0] - FRAMES'(1);
    assign w_popped     = r_fstack[w_fd_top];

    // Next-state decode. Every error path leaves the next-state values at
    // their defaults, which is what keeps index/base/frames/memory intact.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_nxt_index  = r_index;
        w_nxt_base   = r_base;
        w_nxt_fdepth = r_fdepth;
        w_we         = 1'b0;
        w_wa         = r_index[DEPTH-1:0];
        w_wd         = i_data;
        w_fpush      = 1'b0;
        w_complete   = 1'b0;
        w_start_copy = 1'b0;
        w_err        = ST_NONE;

        if (r_state == S_COPY) begin
            w_we = 1'b1;
            w_wa = r_dst[DEPTH-1:0];
            w_wd = r_mem[r_src];
            if (r_cnt == ONE) begin
                // Last entry moved: r_dst is base+arg-1 at this point.
                w_complete   = 1'b1;
                w_nxt_index  = r_dst + ONE;
                w_nxt_base   = w_popped;
                w_nxt_fdepth = r_fdepth - FRAMES'(1) - (FRAMES+1)'(0);
            end
        end else if (i_req_valid) begin
            w_complete = 1'b1;
            case (w_op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (r_index == CAP) begin
                        w_err = ST_OVERFLOW;
                    end else begin
                        w_we        = 1'b1;
                        w_nxt_index = r_index + ONE;
                    end
                end
                OP_POP: begin
                    // arg+1 > avail rewritten as arg >= avail to avoid overflow.
                    if (i_arg >= w_avail) begin
                        w_err = ST_UNDERFLOW;
                    end else begin
                        w_nxt_index = r_index - i_arg - ONE;
                    end
                end
                OP_REPLACE: begin
                    if (w_avail == '0) begin
                        w_err = ST_UNDERFLOW;
                    end else begin
                        w_we = 1'b1;
                        w_wa = r_index[DEPTH-1:0] - DEPTH'(1);
                    end
                end
                OP_CALL: begin
                    if (i_arg > w_avail) begin
                        w_err = ST_UNDERFLOW;
                    end else if (r_fdepth == FCAP) begin
                        w_err = ST_FRAME_OVERFLOW;
                    end else begin
                        w_fpush      = 1'b1;
                        w_nxt_base   = r_index - i_arg;
                        w_nxt_fdepth = r_fdepth + (FRAMES+1)'(1);
                    end
                end
                OP_RETURN: begin
                    if (r_fdepth == '0) begin
                        w_err = ST_FRAME_UNDERFLOW;
                    end else if (i_arg > w_avail) begin
                        w_err = ST_UNDERFLOW;
                    end else if (i_arg != '0 && i_arg != w_avail) begin
                        // Results sit above the frame's locals: move them down.
                        w_complete   = 1'b0;
                        w_start_copy = 1'b1;
                    end else begin
                        // Results already sit at base (or there are none).
                        w_nxt_index  = r_base + i_arg;
                        w_nxt_base   = w_popped;
                        w_nxt_fdepth = r_fdepth - (FRAMES+1)'(1);
                    end
                end
                OP_LOCAL_GET: begin
                    if (i_arg >= w_avail) begin
                        w_err = ST_BAD_OFFSET;
                    end else if (r_index == CAP) begin
                        w_err = ST_OVERFLOW;
                    end else begin
                        w_we        = 1'b1;
                        w_wd        = r_mem[w_local_addr];
                        w_nxt_index = r_index + ONE;
                    end
                end
                OP_LOCAL_SET: begin
                    if (i_arg >= w_avail) begin
                        w_err = ST_BAD_OFFSET;
                    end else if (i_drop && w_avail == '0) begin
                        w_err = ST_UNDERFLOW;
                    end else begin
                        w_we = 1'b1;
                        w_wa = w_local_addr;
                        if (i_drop) begin
                            w_nxt_index = r_index - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (w_err != ST_NONE) begin
            w_status = w_err;
        end else if (w_nxt_index == CAP) begin
            w_status = ST_FULL;
        end else if (w_nxt_index == w_nxt_base) begin
            w_status = ST_EMPTY;
        end else begin
            w_status = ST_NONE;
        end
    end

    // Tap values as they will be after this edge: forward the write landing
    // on the same edge so the registered taps never show stale data.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (w_nxt_index > (DEPTH+1)'(k)) begin
                if (w_we && w_wa == (w_nxt_index[DEPTH-1:0] - DEPTH'(k + 1))) begin
                    w_tap[k] = w_wd;
                end else begin
                    w_tap[k] = r_mem[w_nxt_index[DEPTH-1:0] - DEPTH'(k + 1)];
                end
            end else begin
                w_tap[k] = '0;
            end
        end
    end

    // FSM and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_status     <= ST_EMPTY;
            r_index      <= '0;
            r_base       <= '0;
            r_fdepth     <= '0;
            r_top0       <= '0;
            r_top1       <= '0;
            r_top2       <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_cnt        <= '0;
        end else begin
            r_resp_valid <= w_complete;
            if (w_complete) begin
                r_state     <= S_IDLE;
                r_req_ready <= 1'b1;
                r_status    <= w_status;
                r_index     <= w_nxt_index;
                r_base      <= w_nxt_base;
                r_fdepth    <= w_nxt_fdepth;
                r_top0      <= w_tap[0];
                r_top1      <= w_tap[1];
                r_top2      <= w_tap[2];
            end else if (w_start_copy) begin
                r_state     <= S_COPY;
                r_req_ready <= 1'b0;
                r_src       <= r_index[DEPTH-1:0] - i_arg[DEPTH-1:0];
                r_dst       <= r_base;
                r_cnt       <= i_arg;
            end else if (r_state == S_COPY) begin
                r_src <= r_src + DEPTH'(1);
                r_dst <= r_dst + ONE;
                r_cnt <= r_cnt - ONE;
            end
        end
    end

    // NOTE: the storage arrays have no reset; their contents are don't-care
    // until written, and only positions below index are ever read back.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_wa] <= w_wd;
        end
        if (!reset && w_fpush) begin
            r_fstack[r_fdepth[FRAMES-1:0]] <= r_base;
        end
    end

`ifdef FRAME_STACK_HIGH_WATER_EN
    logic [DEPTH:0] r_high_water;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_high_water <= '0;
        end else if (w_complete && w_nxt_index > r_high_water) begin
            r_high_water <= w_nxt_index;
        end
    end

    assign o_high_water = r_high_water;
`else
    assign o_high_water = '0;
`endif

    assign o_req_ready   = r_req_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_status      = r_status;
    assign o_index       = r_index;
    assign o_base        = r_base;
    assign o_frame_depth = r_fdepth;
    assign o_top0        = r_top0;
    assign o_top1        = r_top1;
    assign o_top2        = r_top2;

endmodule

// File: tb/tb_frame_stack.sv
// ---------------------------------------------------------------------------
// tb_frame_stack
//
// Self-checking bench for frame_stack. A behavioural model (plain array for
// the stack, a queue for saved frame bases) predicts index, base, frame
// depth, status, taps, high-water mark and response latency for each
// request. Directed scenarios cover the documented cases, followed by a
// randomized request stream.
// ---------------------------------------------------------------------------
module tb_frame_stack;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 7;
    localparam int FRAMES = 3;
    localparam int CAP    = 1 << DEPTH;
    localparam int FCAP   = 1 << FRAMES;

    localparam int OP_NOP = 0, OP_PUSH = 1, OP_POP = 2, OP_REPLACE = 3;
    localparam int OP_CALL = 4, OP_RETURN = 5, OP_LGET = 6, OP_LSET = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [2:0]        i_op;
    logic [DEPTH:0]    i_arg;
    logic [WIDTH-1:0]  i_data;
    logic              i_drop;
    logic              o_resp_valid;
    logic [2:0]        o_status;
    logic [DEPTH:0]    o_index;
    logic [DEPTH:0]    o_base;
    logic [FRAMES:0]   o_frame_depth;
    logic [WIDTH-1:0]  o_top0, o_top1, o_top2;
    logic [DEPTH:0]    o_high_water;

    frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_op          (i_op),
        .i_arg         (i_arg),
        .i_data        (i_data),
        .i_drop        (i_drop),
        .o_resp_valid  (o_resp_valid),
        .o_status      (o_status),
        .o_index       (o_index),
        .o_base        (o_base),
        .o_frame_depth (o_frame_depth),
        .o_top0        (o_top0),
        .o_top1        (o_top1),
        .o_top2        (o_top2),
        .o_high_water  (o_high_water)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_mem [0:CAP-1];
    int               m_index, m_base, m_status, m_hw;
    int               m_frames [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_index  = 0;
        m_base   = 0;
        m_status = 1;
        m_hw     = 0;
        m_frames.delete();
    endfunction

    // Applies one request to the model; returns the expected number of
    // cycles from acceptance to the response pulse.
    function automatic int model_step(input int op, input int arg,
                                      input logic [WIDTH-1:0] data, input bit drop);
        int avail;
        int err;
        int lat;
        int src;
        avail = m_index - m_base;
        err   = 0;
        lat   = 1;
        case (op)
            OP_PUSH: begin
                if (m_index == CAP) err = 4;
                else begin m_mem[m_index] = data; m_index++; end
            end
            OP_POP: begin
                if (arg + 1 > avail) err = 3;
                else m_index = m_index - (arg + 1);
            end
            OP_REPLACE: begin
                if (avail == 0) err = 3;
                else m_mem[m_index - 1] = data;
            end
            OP_CALL: begin
                if (arg > avail) err = 3;
                else if (m_frames.size() == FCAP) err = 6;
                else begin m_frames.push_back(m_base); m_base = m_index - arg; end
            end
            OP_RETURN: begin
                if (m_frames.size() == 0) err = 7;
                else if (arg > avail) err = 3;
                else begin
                    src = m_index - arg;
                    if (arg > 0 && src != m_base) lat = arg + 1;
                    for (int k = 0; k < arg; k++) m_mem[m_base + k] = m_mem[src + k];
                    m_index = m_base + arg;
                    m_base  = m_frames.pop_back();
                end
            end
            OP_LGET: begin
                if (m_base + arg >= m_index) err = 5;
                else if (m_index == CAP) err = 4;
                else begin m_mem[m_index] = m_mem[m_base + arg]; m_index++; end
            end
            OP_LSET: begin
                if (m_base + arg >= m_index) err = 5;
                else if (drop && m_index == m_base) err = 3;
                else begin
                    m_mem[m_base + arg] = data;
                    if (drop) m_index--;
                end
            end
            default: ;
        endcase
        if (err != 0)             m_status = err;
        else if (m_index == CAP)  m_status = 2;
        else if (m_index == m_base) m_status = 1;
        else                      m_status = 0;
        if (m_index > m_hw) m_hw = m_index;
        return lat;
    endfunction

    function automatic logic [WIDTH-1:0] exp_tap(input int k);
        if (m_index - 1 - k >= 0) return m_mem[m_index - 1 - k];
        return '0;
    endfunction

    task automatic compare_state();
        check("index",       64'(o_index),       64'(m_index));
        check("base",        64'(o_base),        64'(m_base));
        check("frame_depth", 64'(o_frame_depth), 64'(m_frames.size()));
        check("status",      64'(o_status),      64'(m_status));
        check("top0",        64'(o_top0),        64'(exp_tap(0)));
        check("top1",        64'(o_top1),        64'(exp_tap(1)));
        check("top2",        64'(o_top2),        64'(exp_tap(2)));
        check("req_ready",   64'(o_req_ready),   64'(1));
`ifdef FRAME_STACK_HIGH_WATER_EN
        check("high_water",  64'(o_high_water),  64'(m_hw));
`else
        check("high_water",  64'(o_high_water),  64'(0));
`endif
    endtask

    // Called at a falling edge; returns at the falling edge where the
    // response pulse is observed.
    task automatic do_req(input int op, input int arg, input logic [WIDTH-1:0] data,
                          input bit drop, output int lat);
        int exp_lat;
        bit seen;
        i_req_valid = 1'b1;
        i_op        = 3'(op);
        i_arg       = (DEPTH+1)'(arg);
        i_data      = data;
        i_drop      = drop;
        exp_lat     = model_step(op, arg, data, drop);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (o_resp_valid) seen = 1'b1;
            else check("ready_low_while_busy", 64'(o_req_ready), 64'(0));
        end
        check("resp_seen", 64'(seen), 64'(1));
        check("latency",   64'(lat),  64'(exp_lat));
        compare_state();
    endtask

    // Reset with a PUSH request held valid, which must be ignored.
    task automatic do_reset();
        reset       = 1'b1;
        i_req_valid = 1'b1;
        i_op        = 3'(OP_PUSH);
        i_arg       = '0;
        i_data      = 32'hDEAD_BEEF;
        i_drop      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset       = 1'b0;
        i_req_valid = 1'b0;
        model_reset();
        check("reset_resp_valid", 64'(o_resp_valid), 64'(0));
        compare_state();
    endtask

    initial begin
        int lat;
        reset       = 1'b1;
        i_req_valid = 1'b0;
        i_op        = '0;
        i_arg       = '0;
        i_data      = '0;
        i_drop      = 1'b0;
        @(negedge clk);
        do_reset();

        // Three pushes, back to back
        do_req(OP_PUSH, 0, 32'hA, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'hB, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'hC, 1'b0, lat);
        check("s1_index",  64'(o_index),  64'(3));
        check("s1_top0",   64'(o_top0),   64'(32'hC));
        check("s1_top1",   64'(o_top1),   64'(32'hB));
        check("s1_top2",   64'(o_top2),   64'(32'hA));
        check("s1_status", 64'(o_status), 64'(0));
`ifdef FRAME_STACK_HIGH_WATER_EN
        check("s1_high_water", 64'(o_high_water), 64'(3));
`else
        check("s1_high_water", 64'(o_high_water), 64'(0));
`endif

        // Pops and underflow
        do_req(OP_POP, 1, '0, 1'b0, lat);
        check("s2_index", 64'(o_index), 64'(1));
        check("s2_top0",  64'(o_top0),  64'(32'hA));
        do_req(OP_POP, 1, '0, 1'b0, lat);
        check("s2_underflow", 64'(o_status), 64'(3));
        check("s2_index_kept", 64'(o_index), 64'(1));

        // Fill to capacity, then overflow
        for (int n = 1; n < CAP; n++) do_req(OP_PUSH, 0, $urandom, 1'b0, lat);
        check("s3_full", 64'(o_status), 64'(2));
        do_req(OP_PUSH, 0, 32'h1234, 1'b0, lat);
        check("s3_overflow", 64'(o_status), 64'(4));
        check("s3_index",    64'(o_index),  64'(CAP));

        // Call / local access / return with result copy
        do_reset();
        do_req(OP_PUSH, 0, 32'd1, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd2, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd3, 1'b0, lat);
        do_req(OP_CALL, 2, '0, 1'b0, lat);
        check("s4_base",  64'(o_base),        64'(1));
        check("s4_depth", 64'(o_frame_depth), 64'(1));
        do_req(OP_LGET, 1, '0, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd9, 1'b0, lat);
        do_req(OP_RETURN, 2, '0, 1'b0, lat);
        check("s4_ret_latency", 64'(lat),    64'(3));
        check("s4_ret_index",   64'(o_index), 64'(3));
        check("s4_ret_base",    64'(o_base),  64'(0));
        check("s4_ret_top0",    64'(o_top0),  64'(9));
        check("s4_ret_top1",    64'(o_top1),  64'(3));

        // Frame-stack overflow and underflow
        do_reset();
        do_req(OP_PUSH, 0, 32'd7, 1'b0, lat);
        for (int n = 0; n < FCAP; n++) do_req(OP_CALL, 0, '0, 1'b0, lat);
        do_req(OP_CALL, 0, '0, 1'b0, lat);
        check("s5_frame_overflow", 64'(o_status),      64'(6));
        check("s5_depth_full",     64'(o_frame_depth), 64'(FCAP));
        for (int n = 0; n < FCAP; n++) do_req(OP_RETURN, 0, '0, 1'b0, lat);
        do_req(OP_RETURN, 0, '0, 1'b0, lat);
        check("s5_frame_underflow", 64'(o_status), 64'(7));

        // Reset in the middle of a RETURN copy
        do_reset();
        do_req(OP_PUSH, 0, 32'd1, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd2, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd3, 1'b0, lat);
        do_req(OP_CALL, 0, '0, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd4, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd5, 1'b0, lat);
        do_req(OP_PUSH, 0, 32'd6, 1'b0, lat);
        i_req_valid = 1'b1;
        i_op        = 3'(OP_RETURN);
        i_arg       = (DEPTH+1)'(2);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("s6_copy_busy", 64'(o_req_ready), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        check("s6_index",  64'(o_index),       64'(0));
        check("s6_base",   64'(o_base),        64'(0));
        check("s6_depth",  64'(o_frame_depth), 64'(0));
        check("s6_status", 64'(o_status),      64'(1));
        check("s6_ready",  64'(o_req_ready),   64'(1));
        reset = 1'b0;
        model_reset();

        // Randomized stream
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int r;
            int op;
            int arg;
            int avail;
            r     = int'($urandom_range(99, 0));
            avail = m_index - m_base;
            if      (r < 5)  op = OP_NOP;
            else if (r < 35) op = OP_PUSH;
            else if (r < 47) op = OP_POP;
            else if (r < 55) op = OP_REPLACE;
            else if (r < 65) op = OP_CALL;
            else if (r < 75) op = OP_RETURN;
            else if (r < 87) op = OP_LGET;
            else             op = OP_LSET;
            case (op)
                OP_POP:    arg = int'($urandom_range((avail < 4) ? avail : 4, 0));
                OP_CALL:   arg = int'($urandom_range((avail < 4) ? avail + 1 : 4, 0));
                OP_RETURN: arg = int'($urandom_range((avail < 8) ? avail + 1 : 8, 0));
                OP_LGET,
                OP_LSET:   arg = int'($urandom_range(avail, 0));
                default:   arg = 0;
            endcase
            if ($urandom_range(15, 0) == 0) arg = int'($urandom_range(255, 0));
            if ($urandom_range(7, 0) == 0) @(negedge clk);
            do_req(op, arg, $urandom, 1'($urandom_range(1, 0)), lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit reached expected test end");
        $fatal(1, "watchdog expired");
    end

endmodule
